// File: rtl/coreaxitoahbl_wstrb_sequencer_if.sv
// Write-beat input and AHB-Lite transfer-request output of the strobe sequencer.
// The slave modport is the sequencer's view; master is the view of whatever drives it.
interface coreaxitoahbl_wstrb_sequencer_if #(
    parameter int ADDR_WIDTH = 32
) ();
    logic                  in_valid;
    logic                  in_ready;
    logic [ADDR_WIDTH-1:0] in_addr;
    logic [7:0]            in_wstrb;
    logic                  out_valid;
    logic                  out_ready;
    logic [ADDR_WIDTH-1:0] out_addr;
    logic [2:0]            out_size;
    logic                  out_last;
    logic                  beat_done;

    modport slave (
        input  in_valid, in_addr, in_wstrb, out_ready,
        output in_ready, out_valid, out_addr, out_size, out_last, beat_done
    );

    modport master (
        output in_valid, in_addr, in_wstrb, out_ready,
        input  in_ready, out_valid, out_addr, out_size, out_last, beat_done
    );
endinterface

// File: rtl/coreaxitoahbl_wstrb_sequencer.sv
// Splits one 64-bit write beat with sparse byte strobes into a sequence of
// naturally aligned AHB-Lite transfers, lowest address first.
module coreaxitoahbl_wstrb_sequencer #(
    parameter int ADDR_WIDTH = 32,
    parameter int MAX_SIZE   = 3
) (
    input  logic ACLK,
    input  logic ARESETN,
    coreaxitoahbl_wstrb_sequencer_if.slave bus
);
    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] ISSUE = 1'b1;

    typedef struct packed {
        logic [2:0] off;
        logic [2:0] size;
        logic [7:0] cov;
        logic       last;
    } pick_t;

    // Lowest pending byte, widened to the largest aligned fully-strobed chunk.
    function automatic pick_t pickTransfer(input logic [7:0] mask);
        pick_t      r;
        logic       found;
        logic [7:0] chunk;
        r     = '0;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            if (!found && mask[i]) begin
                r.off = 3'(i);
                found = 1'b1;
            end
        end
        r.cov = 8'd1 << r.off;
        for (int s = 1; s <= MAX_SIZE; s++) begin
            chunk = 8'((1 << (1 << s)) - 1) << r.off;
            if (((int'(r.off) % (1 << s)) == 0) && ((mask & chunk) == chunk)) begin
                r.size = 3'(s);
                r.cov  = chunk;
            end
        end
        r.last = (mask & ~r.cov) == 8'd0;
        return r;
    endfunction

    logic [0:0]            stateReg;
    logic [ADDR_WIDTH-1:0] baseReg;
    logic [7:0]            pendReg;
    logic [7:0]            coverReg;
    logic                  outValidReg;
    logic [ADDR_WIDTH-1:0] outAddrReg;
    logic [2:0]            outSizeReg;
    logic                  outLastReg;
    logic                  beatDoneReg;

    logic [ADDR_WIDTH-1:0] inBase;
    logic [7:0]            remaining;
    logic [7:0]            pickMask;
    pick_t                 pick;
    logic [ADDR_WIDTH-1:0] pickOff;

    // Base is 8-byte aligned, so OR-ing the offset in is the carry-free add.
    assign inBase    = bus.in_addr & ~{{(ADDR_WIDTH-3){1'b0}}, 3'b111};
    assign remaining = pendReg & ~coverReg;
    assign pickOff   = {{(ADDR_WIDTH-3){1'b0}}, pick.off};

    always_comb begin
        pickMask = remaining;
        if (stateReg == IDLE) begin
            pickMask = bus.in_wstrb;
        end
        pick = pickTransfer(pickMask);
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            stateReg    <= IDLE;
            baseReg     <= '0;
            pendReg     <= '0;
            coverReg    <= '0;
            outValidReg <= 1'b0;
            outAddrReg  <= '0;
            outSizeReg  <= '0;
            outLastReg  <= 1'b0;
            beatDoneReg <= 1'b0;
        end else begin
            beatDoneReg <= 1'b0;
            case (stateReg)
                IDLE: begin
                    if (bus.in_valid) begin
                        if (bus.in_wstrb == 8'd0) begin
                            beatDoneReg <= 1'b1;
                        end else begin
                            stateReg    <= ISSUE;
                            baseReg     <= inBase;
                            pendReg     <= bus.in_wstrb;
                            coverReg    <= pick.cov;
                            outValidReg <= 1'b1;
                            outAddrReg  <= inBase | pickOff;
                            outSizeReg  <= pick.size;
                            outLastReg  <= pick.last;
                        end
                    end
                end
                default: begin
                    if (outValidReg && bus.out_ready) begin
                        if (outLastReg) begin
                            stateReg    <= IDLE;
                            pendReg     <= '0;
                            coverReg    <= '0;
                            outValidReg <= 1'b0;
                            beatDoneReg <= 1'b1;
                        end else begin
                            pendReg    <= remaining;
                            coverReg   <= pick.cov;
                            outAddrReg <= baseReg | pickOff;
                            outSizeReg <= pick.size;
                            outLastReg <= pick.last;
                        end
                    end
                end
            endcase
        end
    end

    assign bus.in_ready  = (stateReg == IDLE);
    assign bus.out_valid = outValidReg;
    assign bus.out_addr  = outAddrReg;
    assign bus.out_size  = outSizeReg;
    assign bus.out_last  = outLastReg;
    assign bus.beat_done = beatDoneReg;
endmodule

// File: tb/tb_coreaxitoahbl_wstrb_sequencer.sv
// Directed bench: a vector table of beats with hand-computed transfer lists,
// plus sequences for backpressure, empty strobes and mid-beat reset.
module tb_coreaxitoahbl_wstrb_sequencer;
    logic ACLK;
    logic ARESETN;

    coreaxitoahbl_wstrb_sequencer_if #(.ADDR_WIDTH(32)) ifA ();
    coreaxitoahbl_wstrb_sequencer_if #(.ADDR_WIDTH(32)) ifB ();

    coreaxitoahbl_wstrb_sequencer #(.ADDR_WIDTH(32), .MAX_SIZE(3)) dutA (
        .ACLK(ACLK), .ARESETN(ARESETN), .bus(ifA)
    );
    coreaxitoahbl_wstrb_sequencer #(.ADDR_WIDTH(32), .MAX_SIZE(1)) dutB (
        .ACLK(ACLK), .ARESETN(ARESETN), .bus(ifB)
    );

    initial ACLK = 1'b0;
    always #5 ACLK = ~ACLK;

    typedef struct {
        int          dutSel;
        logic [31:0] addr;
        logic [7:0]  wstrb;
        int          nXfer;
        logic [31:0] expAddr [4];
        logic [2:0]  expSize [4];
    } vec_t;

    vec_t vecs [8];
    int   testsRun = 0;
    int   testsFailed = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        testsRun++;
        if (act !== exp) begin
            testsFailed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic setVec(input int idx, input int sel, input logic [31:0] addr,
                          input logic [7:0] wstrb, input int n,
                          input logic [31:0] a0, input logic [2:0] s0,
                          input logic [31:0] a1, input logic [2:0] s1,
                          input logic [31:0] a2, input logic [2:0] s2,
                          input logic [31:0] a3, input logic [2:0] s3);
        vecs[idx].dutSel = sel;
        vecs[idx].addr   = addr;
        vecs[idx].wstrb  = wstrb;
        vecs[idx].nXfer  = n;
        vecs[idx].expAddr[0] = a0; vecs[idx].expSize[0] = s0;
        vecs[idx].expAddr[1] = a1; vecs[idx].expSize[1] = s1;
        vecs[idx].expAddr[2] = a2; vecs[idx].expSize[2] = s2;
        vecs[idx].expAddr[3] = a3; vecs[idx].expSize[3] = s3;
    endtask

    task automatic driveIn(input int sel, input logic v, input logic [31:0] addr, input logic [7:0] wstrb);
        if (sel == 0) begin
            ifA.in_valid = v; ifA.in_addr = addr; ifA.in_wstrb = wstrb;
        end else begin
            ifB.in_valid = v; ifB.in_addr = addr; ifB.in_wstrb = wstrb;
        end
    endtask

    task automatic sample(input int sel, output logic v, output logic [31:0] a,
                          output logic [2:0] s, output logic l, output logic bd, output logic rdy);
        if (sel == 0) begin
            v = ifA.out_valid; a = ifA.out_addr; s = ifA.out_size;
            l = ifA.out_last; bd = ifA.beat_done; rdy = ifA.in_ready;
        end else begin
            v = ifB.out_valid; a = ifB.out_addr; s = ifB.out_size;
            l = ifB.out_last; bd = ifB.beat_done; rdy = ifB.in_ready;
        end
    endtask

    task automatic runBeat(input int idx);
        logic v, l, bd, rdy;
        logic [31:0] a;
        logic [2:0] s;
        int sel;
        sel = vecs[idx].dutSel;
        @(negedge ACLK);
        ifA.out_ready = 1'b1;
        ifB.out_ready = 1'b1;
        driveIn(sel, 1'b1, vecs[idx].addr, vecs[idx].wstrb);
        @(posedge ACLK);
        #1 driveIn(sel, 1'b0, 32'h0, 8'h0);
        for (int k = 0; k < vecs[idx].nXfer; k++) begin
            @(negedge ACLK);
            sample(sel, v, a, s, l, bd, rdy);
            check($sformatf("v%0d.x%0d.valid", idx, k), 32'(v), 32'd1);
            check($sformatf("v%0d.x%0d.addr", idx, k), a, vecs[idx].expAddr[k]);
            check($sformatf("v%0d.x%0d.size", idx, k), 32'(s), 32'(vecs[idx].expSize[k]));
            check($sformatf("v%0d.x%0d.last", idx, k), 32'(l), 32'(k == vecs[idx].nXfer - 1));
            if (k == 0) check($sformatf("v%0d.busy_in_ready", idx), 32'(rdy), 32'd0);
        end
        @(negedge ACLK);
        sample(sel, v, a, s, l, bd, rdy);
        check($sformatf("v%0d.end_valid", idx), 32'(v), 32'd0);
        check($sformatf("v%0d.beat_done", idx), 32'(bd), 32'd1);
        check($sformatf("v%0d.end_in_ready", idx), 32'(rdy), 32'd1);
        $display("[TB] beat %0d addr=%h wstrb=%h transfers=%0d checked", idx,
                 vecs[idx].addr, vecs[idx].wstrb, vecs[idx].nXfer);
    endtask

    initial begin
        logic v, l, bd, rdy;
        logic [31:0] a;
        logic [2:0] s;

        setVec(0, 0, 32'h1000, 8'hFF, 1, 32'h1000, 3, 0, 0, 0, 0, 0, 0);
        setVec(1, 0, 32'h2005, 8'h7E, 4, 32'h2001, 0, 32'h2002, 1, 32'h2004, 1, 32'h2006, 0);
        setVec(2, 1, 32'h3000, 8'h0F, 2, 32'h3000, 1, 32'h3002, 1, 0, 0, 0, 0);
        setVec(3, 0, 32'h4008, 8'hF0, 1, 32'h400C, 2, 0, 0, 0, 0, 0, 0);
        setVec(4, 0, 32'h5003, 8'h3C, 2, 32'h5002, 1, 32'h5004, 1, 0, 0, 0, 0);
        setVec(5, 1, 32'h6000, 8'hFF, 4, 32'h6000, 1, 32'h6002, 1, 32'h6004, 1, 32'h6006, 1);
        setVec(6, 0, 32'h7000, 8'h55, 4, 32'h7000, 0, 32'h7002, 0, 32'h7004, 0, 32'h7006, 0);
        setVec(7, 0, 32'h8000, 8'hC3, 2, 32'h8000, 1, 32'h8006, 1, 0, 0, 0, 0);

        ARESETN = 1'b0;
        driveIn(0, 1'b0, 32'h0, 8'h0);
        driveIn(1, 1'b0, 32'h0, 8'h0);
        ifA.out_ready = 1'b1;
        ifB.out_ready = 1'b1;
        repeat (2) @(negedge ACLK);
        sample(0, v, a, s, l, bd, rdy);
        check("reset.valid", 32'(v), 32'd0);
        check("reset.addr", a, 32'd0);
        check("reset.size", 32'(s), 32'd0);
        check("reset.beat_done", 32'(bd), 32'd0);
        ARESETN = 1'b1;
        @(negedge ACLK);
        sample(0, v, a, s, l, bd, rdy);
        check("post_reset.in_ready", 32'(rdy), 32'd1);

        for (int i = 0; i < 8; i++) runBeat(i);

        // Backpressure: first transfer of 0x81 held while out_ready is low.
        @(negedge ACLK);
        ifA.out_ready = 1'b0;
        driveIn(0, 1'b1, 32'h9000, 8'h81);
        @(posedge ACLK);
        #1 driveIn(0, 1'b0, 32'h0, 8'h0);
        for (int c = 0; c < 4; c++) begin
            @(negedge ACLK);
            sample(0, v, a, s, l, bd, rdy);
            check($sformatf("bp.hold%0d.valid", c), 32'(v), 32'd1);
            check($sformatf("bp.hold%0d.addr", c), a, 32'h9000);
            check($sformatf("bp.hold%0d.size", c), 32'(s), 32'd0);
            check($sformatf("bp.hold%0d.last", c), 32'(l), 32'd0);
        end
        ifA.out_ready = 1'b1;
        @(negedge ACLK);
        sample(0, v, a, s, l, bd, rdy);
        check("bp.x1.addr", a, 32'h9007);
        check("bp.x1.size", 32'(s), 32'd0);
        check("bp.x1.last", 32'(l), 32'd1);
        @(negedge ACLK);
        sample(0, v, a, s, l, bd, rdy);
        check("bp.beat_done", 32'(bd), 32'd1);
        $display("[TB] backpressure beat wstrb=81 checked");

        // Empty strobe: accepted, retired without any transfer.
        @(negedge ACLK);
        driveIn(0, 1'b1, 32'hA000, 8'h00);
        @(posedge ACLK);
        #1 driveIn(0, 1'b0, 32'h0, 8'h0);
        @(negedge ACLK);
        sample(0, v, a, s, l, bd, rdy);
        check("zero.valid", 32'(v), 32'd0);
        check("zero.beat_done", 32'(bd), 32'd1);
        check("zero.in_ready", 32'(rdy), 32'd1);
        @(negedge ACLK);
        sample(0, v, a, s, l, bd, rdy);
        check("zero.beat_done_clear", 32'(bd), 32'd0);
        check("zero.valid_after", 32'(v), 32'd0);
        $display("[TB] empty-strobe beat checked");

        // Reset asserted while the second transfer of 0x7E is presented.
        @(negedge ACLK);
        driveIn(0, 1'b1, 32'h2005, 8'h7E);
        @(posedge ACLK);
        #1 driveIn(0, 1'b0, 32'h0, 8'h0);
        @(negedge ACLK);
        @(negedge ACLK);
        sample(0, v, a, s, l, bd, rdy);
        check("rst.pre.addr", a, 32'h2002);
        #1 ARESETN = 1'b0;
        #1 sample(0, v, a, s, l, bd, rdy);
        check("rst.now.valid", 32'(v), 32'd0);
        check("rst.now.addr", a, 32'd0);
        check("rst.now.size", 32'(s), 32'd0);
        check("rst.now.last", 32'(l), 32'd0);
        check("rst.now.beat_done", 32'(bd), 32'd0);
        @(negedge ACLK);
        ARESETN = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge ACLK);
            sample(0, v, a, s, l, bd, rdy);
            check($sformatf("rst.after%0d.valid", c), 32'(v), 32'd0);
            check($sformatf("rst.after%0d.in_ready", c), 32'(rdy), 32'd1);
        end
        $display("[TB] mid-beat reset checked");

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end
endmodule
